seg_scan_controller: RTL and testbench

- Time-multiplexing scheduler for a 4-digit common-anode 7-segment display.
- Shares one hex-to-7-segment decode path among four hex digits, rotating digit enables at a programmable scan rate.
- Inserts blanking guard time between digits to prevent ghosting; supports leading-zero blanking.
- Sits between the hex counter datapath(s) that produce digit values and the board display pins.

---
 rtl/seg_scan_controller.sv | 108 ++++++++++
 tb/tb_seg_scan_controller.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/seg_scan_controller.sv
// seg_scan_controller: time-multiplexed 4-digit common-anode 7-segment scanner with guard blanking and leading-zero suppression.
module seg_scan_controller #(
    parameter int oldHz  = 50_000_000,
    parameter int scanHz = 1_000,
    parameter int GUARD  = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Enable,
    input  logic [15:0] Digits,
    input  logic [3:0]  DP_in,
    input  logic        Blank_lead,
    output logic [3:0]  Anode,
    output logic [7:0]  SSeg,
    output logic [1:0]  Digit_sel,
    output logic        Frame_done
);
    localparam int DIV = oldHz / scanHz;
    localparam int SHOW_LEN = DIV - GUARD;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);
    localparam logic [6:0] SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GUARD} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    sel_q, sel_d;
    logic [15:0]   digits_q, digits_d;
    logic [3:0]    dp_q, dp_d;
    logic          blank_q, blank_d;
    logic [3:0]    anode_q, anode_d;
    logic [7:0]    sseg_q, sseg_d;
    logic          fd_q, fd_d;
    logic          last, wrap, show;
    logic [3:0]    lead;
    logic [3:0]    hex;

    assign last = presc_q == LAST;
    assign wrap = state_q == S_IDLE || (last && sel_q == 2'd3);

    always_comb begin
        state_d  = S_IDLE;
        presc_d  = '0;
        sel_d    = 2'd0;
        digits_d = digits_q;
        dp_d     = dp_q;
        blank_d  = blank_q;
        if (Enable) begin
            presc_d = (state_q == S_IDLE || last) ? '0 : presc_q + 1'b1;
            sel_d   = state_q == S_IDLE ? 2'd0 : (last ? sel_q + 2'd1 : sel_q);
            state_d = (GUARD == 0 || 32'(presc_d) < SHOW_LEN) ? S_SHOW : S_GUARD;
            if (wrap) begin
                digits_d = Digits;
                dp_d     = DP_in;
                blank_d  = Blank_lead;
            end
        end
    end

    // Outputs are decoded from the next-state values so they land on the same edge as the state change.
    assign lead[3] = blank_d && digits_d[15:12] == 4'h0;
    assign lead[2] = lead[3] && digits_d[11:8] == 4'h0;
    assign lead[1] = lead[2] && digits_d[7:4] == 4'h0;
    assign lead[0] = 1'b0;
    assign hex     = digits_d[{sel_d, 2'b00} +: 4];
    assign show    = state_d == S_SHOW;

    always_comb begin
        anode_d = show ? ~(4'b0001 << sel_d) : 4'hF;
        sseg_d  = show ? {lead[sel_d] ? 7'h7F : SEG[hex], ~dp_d[sel_d]} : 8'hFF;
        fd_d    = state_d != S_IDLE && presc_d == LAST && sel_d == 2'd3;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            sel_q    <= 2'd0;
            digits_q <= '0;
            dp_q     <= '0;
            blank_q  <= 1'b0;
            anode_q  <= 4'hF;
            sseg_q   <= 8'hFF;
            fd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            sel_q    <= sel_d;
            digits_q <= digits_d;
            dp_q     <= dp_d;
            blank_q  <= blank_d;
            anode_q  <= anode_d;
            sseg_q   <= sseg_d;
            fd_q     <= fd_d;
        end
    end

    assign Anode      = anode_q;
    assign SSeg       = sseg_q;
    assign Digit_sel  = sel_q;
    assign Frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_controller.sv
// tb_seg_scan_controller: scoreboard bench comparing GUARD=2 and GUARD=0 scanners against a slot-arithmetic reference model.
module tb_seg_scan_controller;
    localparam int DIV = 8;
    localparam logic [6:0] SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef logic [14:0] obs_t;

    logic        clk = 1'b0;
    logic        rst, en, bl;
    logic [15:0] dig;
    logic [3:0]  dp;
    logic [3:0]  a0, a1;
    logic [7:0]  s0, s1;
    logic [1:0]  sel0, sel1;
    logic        fd0, fd1;

    obs_t  q0[$], q1[$];
    int    checks = 0, passed = 0;
    string phase = "init";

    bit          run = 1'b0;
    int          t = 0;
    logic [15:0] sd = '0;
    logic [3:0]  sdp = '0;
    bit          sbl = 1'b0;

    seg_scan_controller #(.oldHz(8), .scanHz(1), .GUARD(2)) dut_g2 (
        .Clk(clk), .Reset(rst), .Enable(en), .Digits(dig), .DP_in(dp), .Blank_lead(bl),
        .Anode(a0), .SSeg(s0), .Digit_sel(sel0), .Frame_done(fd0)
    );
    seg_scan_controller #(.oldHz(8), .scanHz(1), .GUARD(0)) dut_g0 (
        .Clk(clk), .Reset(rst), .Enable(en), .Digits(dig), .DP_in(dp), .Blank_lead(bl),
        .Anode(a1), .SSeg(s1), .Digit_sel(sel1), .Frame_done(fd1)
    );

    always #5 clk = ~clk;

    // Expected outputs follow directly from elapsed time t within the frame.
    function automatic obs_t expect_for(int g);
        int          w, d;
        logic [15:0] hi;
        logic [3:0]  h, a;
        logic [7:0]  s;
        if (!run) return {4'hF, 8'hFF, 2'd0, 1'b0};
        w  = t % DIV;
        d  = (t / DIV) % 4;
        hi = sd >> (4 * d);
        h  = hi[3:0];
        a  = 4'hF;
        s  = 8'hFF;
        if (w < DIV - g) begin
            a = ~(4'b0001 << d);
            s = {(sbl && d > 0 && hi == 16'h0) ? 7'h7F : SEG[h], ~sdp[d]};
        end
        return {a, s, 2'(d), w == DIV - 1 && d == 3};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            run = 1'b0;
            sd  = '0;
            sdp = '0;
            sbl = 1'b0;
        end else if (!en) begin
            run = 1'b0;
        end else begin
            if (!run) begin
                run = 1'b1;
                t   = 0;
            end else begin
                t = (t + 1) % (4 * DIV);
            end
            if (t == 0) begin
                sd  = dig;
                sdp = dp;
                sbl = bl;
            end
        end
        q0.push_back(expect_for(2));
        q1.push_back(expect_for(0));
        #1;
    endtask

    task automatic check(string name, obs_t got, obs_t exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s/%s t=%0d: got anode=%h sseg=%h sel=%0d fd=%b, expected anode=%h sseg=%h sel=%0d fd=%b",
                      phase, name, t, got[14:11], got[10:3], got[2:1], got[0], exp[14:11], exp[10:3], exp[2:1], exp[0]);
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0) check("guard2", {a0, s0, sel0, fd0}, q0.pop_front());
        if (q1.size() > 0) check("guard0", {a1, s1, sel1, fd1}, q1.pop_front());
    end

    initial begin
        rst = 1'b1; en = 1'b1; dig = 16'h1A80; dp = 4'b0100; bl = 1'b0;
        phase = "reset";
        repeat (3) tick();
        rst = 1'b0;
        phase = "frame_1A80";
        repeat (70) tick();
        phase = "lead_blank";
        dig = 16'h0050; dp = 4'b0000; bl = 1'b1;
        repeat (40) tick();
        phase = "snapshot";
        dig = 16'h1111; bl = 1'b0;
        repeat (40) tick();
        while (t != DIV + 2) tick();
        dig = 16'h2222;
        repeat (40) tick();
        phase = "enable_drop";
        while (t != 2 * DIV + 3) tick();
        en = 1'b0;
        repeat (2) tick();
        en = 1'b1;
        repeat (20) tick();
        phase = "random";
        repeat (3000) begin
            if ($urandom_range(15) == 0) dig = 16'($urandom);
            if ($urandom_range(15) == 0) dp = 4'($urandom);
            if ($urandom_range(31) == 0) bl = ~bl;
            if ($urandom_range(7) == 0) dig[15:8] = 8'h00;
            en  = $urandom_range(63) != 0;
            rst = $urandom_range(499) == 0;
            tick();
        end
        rst = 1'b0; en = 1'b1;
        repeat (4) tick();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (q0.size() == 0 && q1.size() == 0) passed++;
        else $display("FAIL drain: got %0d/%0d queued entries left, expected 0/0", q0.size(), q1.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
